// File: rtl/line_readout_ctrl_pkg.sv
// Shared line-buffer types and widths.
// Used by the readout controller and its bench.
package line_readout_ctrl_pkg;
    localparam int LB_ADDR_W = 11;
    localparam int LB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } lb_state_e;
endpackage

// File: rtl/line_readout_ctrl_if.sv
// Valid/ready pixel stream with end-of-line marker.
interface line_readout_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/line_out_fifo.sv
// Small synchronous FIFO with flush, sized by the
// read-credit scheme so a push never meets a full FIFO.
module line_out_fifo #(
    parameter  int W     = 9,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  pop_data,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;
endmodule

// File: rtl/line_readout_ctrl.sv
// Read side of the ping-pong line buffer: captures each
// line length from the write strobe and streams it back.
module line_readout_ctrl
    import line_readout_ctrl_pkg::*;
#(
    parameter int ADDR_W      = LB_ADDR_W,
    parameter int DATA_W      = LB_DATA_W,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_we,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              rd_re,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    line_readout_ctrl_if.master m,
    output logic              busy,
    output logic              overrun
);
    localparam int CW = $clog2(OFIFO_DEPTH) + 1;

    lb_state_e         state_q, state_d;
    logic              we_prev_q, we_prev_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              rd_re_q, rd_re_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              inflight_q, inflight_d;
    logic              tag_last_q, tag_last_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic              line_end;
    logic              issue_last;
    logic              credit;
    logic              drain_done;
    logic [CW:0]       pending;
    logic              push, pop, flush, empty;
    logic [DATA_W:0]   pop_data;
    logic [CW-1:0]     fifo_count;

    assign line_end   = we_prev_q & ~wr_we;
    assign issue_last = rd_re_q &
        (({1'b0, rd_addr_q} + (ADDR_W+1)'(1)) == len_q);

    // Count every read that will still land in the FIFO.
    assign pending = {1'b0, fifo_count}
                   + (CW+1)'(inflight_q)
                   + (CW+1)'(rd_re_q);
    assign credit  = pending < (CW+1)'(OFIFO_DEPTH);

    assign pop        = ~empty & m.m_ready;
    assign drain_done = ~inflight_q & ~rd_re_q &
        (empty | ((fifo_count == CW'(1)) & pop));

    always_comb begin
        state_d     = state_q;
        we_prev_d   = wr_we;
        last_addr_d = wr_we ? wr_addr : last_addr_q;
        len_d       = len_q;
        rd_re_d     = 1'b0;
        rd_addr_d   = rd_addr_q + ADDR_W'(rd_re_q);
        inflight_d  = rd_re_q;
        tag_last_d  = issue_last;
        overrun_d   = 1'b0;
        flush       = 1'b0;
        unique case (state_q)
            IDLE: ;
            READ: begin
                if (issue_last) state_d = DRAIN;
                else            rd_re_d = credit;
            end
            DRAIN: begin
                if (drain_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new line always wins; an unfinished one is dropped.
        if (line_end) begin
            overrun_d  = (state_q != IDLE) &&
                !((state_q == DRAIN) && drain_done);
            flush      = overrun_d;
            inflight_d = rd_re_q & ~overrun_d;
            state_d    = READ;
            len_d      = {1'b0, last_addr_q} + (ADDR_W+1)'(1);
            rd_addr_d  = '0;
            rd_re_d    = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_prev_q   <= 1'b0;
            last_addr_q <= '0;
            len_q       <= '0;
            rd_re_q     <= 1'b0;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
            tag_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_prev_q   <= we_prev_d;
            last_addr_q <= last_addr_d;
            len_q       <= len_d;
            rd_re_q     <= rd_re_d;
            rd_addr_q   <= rd_addr_d;
            inflight_q  <= inflight_d;
            tag_last_q  <= tag_last_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign push = inflight_q;

    line_out_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (OFIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({tag_last_q, rd_data}),
        .pop       (pop),
        .flush     (flush),
        .pop_data  (pop_data),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign m.m_valid = ~empty;
    assign m.m_last  = ~empty & pop_data[DATA_W];
    assign m.m_data  = empty ? '0 : pop_data[DATA_W-1:0];
    assign rd_re     = rd_re_q;
    assign rd_addr   = rd_addr_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_line_readout_ctrl.sv
// Directed/random bench for line_readout_ctrl with a
// ping-pong RAM model and a per-line pixel scoreboard.
module tb_line_readout_ctrl;
    import line_readout_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_we;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_re;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy, overrun;

    line_readout_ctrl_if #(.DATA_W(8)) bif ();

    line_readout_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .wr_we   (wr_we),
        .wr_addr (wr_addr),
        .rd_re   (rd_re),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .m       (bif),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [2][2048];
    bit         wbank = 1'b0;
    logic       ram_we_prev = 1'b0;
    always @(posedge clk) begin
        if (wr_we) ram[int'(wbank)][wr_addr] <= wr_data;
        if (ram_we_prev && !wr_we) wbank <= ~wbank;
        ram_we_prev <= wr_we;
        if (rd_re) rd_data <= ram[int'(!wbank)][rd_addr];
    end

    int         cyc = 0;
    logic [7:0] cap_d [$];
    bit         cap_l [$];
    int         cap_c [$];
    int         rdre_cnt = 0, ovr_cnt = 0, stall_err = 0, fmax = 0;
    bit         stall_q = 1'b0;
    logic [7:0] sd;
    bit         sl;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bif.m_valid && bif.m_ready) begin
            cap_d.push_back(bif.m_data);
            cap_l.push_back(bif.m_last);
            cap_c.push_back(cyc);
        end
        if (stall_q && !reset && !overrun)
            if (!(bif.m_valid && bif.m_data == sd && bif.m_last == sl))
                stall_err <= stall_err + 1;
        stall_q <= bif.m_valid && !bif.m_ready;
        sd      <= bif.m_data;
        sl      <= bif.m_last;
        if (rd_re)   rdre_cnt <= rdre_cnt + 1;
        if (overrun) ovr_cnt  <= ovr_cnt + 1;
        if (int'(dut.fifo_count) > fmax) fmax <= int'(dut.fifo_count);
    end

    int         n_assert = 0, n_fail = 0;
    bit         rdy = 1'b1, tog = 1'b0;
    logic [7:0] exp_q [$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bif.m_ready = tog ? ~bif.m_ready : rdy;
    endtask

    task automatic write_line(int n, bit fixed);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            wr_we   = 1'b1;
            wr_addr = 11'(i);
            wr_data = fixed ? 8'(32'hA0 + i) : 8'($urandom);
            exp_q.push_back(wr_data);
            tick();
        end
        wr_we   = 1'b0;
        wr_addr = '0;
        tick();
    endtask

    task automatic wait_done(string tag, int limit);
        int k = 0;
        while ((busy || bif.m_valid) && k < limit) begin
            tick();
            k++;
        end
        chk({tag, " timeout"}, 32'(k < limit), 1);
    endtask

    task automatic check_stream(string tag, int base, bit consec);
        int n = cap_d.size() - base;
        int bad = 0, lasts = 0, lastpos = -1;
        chk({tag, " beats"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            if (cap_d[base+i] !== exp_q[i]) bad++;
            if (cap_l[base+i]) begin
                lasts++;
                lastpos = i;
            end
        end
        chk({tag, " data errors"}, bad, 0);
        chk({tag, " m_last count"}, lasts, 1);
        chk({tag, " m_last position"}, lastpos, exp_q.size() - 1);
        if (consec && n > 0)
            chk({tag, " bubbles"}, cap_c[base+n-1] - cap_c[base], n - 1);
    endtask

    task automatic check_quiet(string tag);
        chk({tag, " rd_re"},   32'(rd_re), 0);
        chk({tag, " rd_addr"}, 32'(rd_addr), 0);
        chk({tag, " m_valid"}, 32'(bif.m_valid), 0);
        chk({tag, " m_last"},  32'(bif.m_last), 0);
        chk({tag, " m_data"},  32'(bif.m_data), 0);
        chk({tag, " busy"},    32'(busy), 0);
        chk({tag, " overrun"}, 32'(overrun), 0);
        chk({tag, " state"},   32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        int base, r0, o0;
        reset       = 1'b1;
        wr_we       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        bif.m_ready = 1'b1;
        repeat (3) tick();
        check_quiet("reset");
        reset = 1'b0;
        tick();

        // 8-pixel line, fixed data, downstream always ready
        base = cap_d.size();
        r0   = rdre_cnt;
        write_line(8, 1'b1);
        chk("t1 rd_re at t+1", 32'(rd_re), 1);
        chk("t1 rd_addr at t+1", 32'(rd_addr), 0);
        wait_done("t1", 50);
        check_stream("t1", base, 1'b1);
        chk("t1 reads", rdre_cnt - r0, 8);
        chk("t1 rd_addr end", 32'(rd_addr), 8);

        // Full 2048-pixel line
        base = cap_d.size();
        r0   = rdre_cnt;
        write_line(2048, 1'b0);
        chk("t2 len", 32'(dut.len_q), 2048);
        wait_done("t2", 2200);
        check_stream("t2", base, 1'b1);
        chk("t2 reads", rdre_cnt - r0, 2048);
        chk("t2 rd_addr wrap", 32'(rd_addr), 0);

        // 16 pixels with m_ready toggling every cycle
        base = cap_d.size();
        tog  = 1'b1;
        write_line(16, 1'b0);
        wait_done("t3", 200);
        tog = 1'b0;
        tick();
        check_stream("t3", base, 1'b0);
        chk("t3 stall hold", stall_err, 0);
        chk("t3 fifo bound", 32'(fmax <= 4), 1);

        // 64-pixel line stalled, then a 4-pixel line overruns it
        rdy = 1'b0;
        tick();
        base = cap_d.size();
        o0   = ovr_cnt;
        write_line(64, 1'b0);
        repeat (4) tick();
        write_line(4, 1'b0);
        repeat (8) tick();
        rdy = 1'b1;
        tick();
        wait_done("t4", 100);
        check_stream("t4", base, 1'b0);
        chk("t4 overrun pulses", ovr_cnt - o0, 1);

        // Single-pixel line
        base = cap_d.size();
        o0   = ovr_cnt;
        write_line(1, 1'b0);
        wait_done("t5a", 50);
        check_stream("t5a", base, 1'b1);
        chk("t5a no overrun", ovr_cnt - o0, 0);

        // Reset in the middle of a 32-pixel readout
        write_line(32, 1'b0);
        repeat (10) tick();
        reset = 1'b1;
        #1;
        check_quiet("t5b async reset");
        tick();
        reset = 1'b0;
        base  = cap_d.size();
        repeat (40) tick();
        chk("t5b beats after reset", cap_d.size() - base, 0);
        chk("t5b busy after reset", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
